// File: rtl/ntt_sequencer.sv
// Address/twiddle sequencer driving one butterfly_core over a 256-entry polynomial RAM (NTT / INVNTT).
// Optional MULT pass (op 2) is built only when NTT_SEQ_MULT_EN is defined.
module ntt_sequencer #(
  parameter int RD_LATENCY = 1,
  parameter int BU_LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic [1:0] bu_mode,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_idx,
  output logic       tw_neg,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);
  localparam int D   = RD_LATENCY + BU_LATENCY;
  localparam int DCW = $clog2(D + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [6:0]     pair_q, pair_d;
  logic [2:0]     layer_q, layer_d;
  logic [6:0]     k_q, k_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [16:0]    dl_q [D];
  logic [16:0]    dl_d [D];

  logic       start_ok, is_inv, is_mult, last_layer, last_pair, grp_end;
  logic [7:0] len, mask, p8, j;
  logic [7:0] sel_a, sel_b;
  logic [6:0] sel_tw;
  logic       sel_neg;

  assign is_inv = (op_q == 2'd1);

`ifdef NTT_SEQ_MULT_EN
  assign start_ok = start && (op != 2'd3);
  assign is_mult  = (op_q == 2'd2);
`else
  assign start_ok = start && (op[1] == 1'b0);
  assign is_mult  = 1'b0;
`endif

  // Pair index p splits into (group, offset); j inserts a zero bit at position log2(len).
  always_comb begin
    len        = is_inv ? (8'd2 << layer_q) : (8'd128 >> layer_q);
    mask       = len - 8'd1;
    p8         = {1'b0, pair_q};
    j          = ((p8 & ~mask) << 1) | (p8 & mask);
    grp_end    = ((p8 & mask) == mask);
    last_pair  = (pair_q == 7'd127);
    last_layer = is_mult || (layer_q == 3'd6);
    sel_a      = j;
    sel_b      = j | len;
    sel_tw     = k_q;
    sel_neg    = 1'b0;
`ifdef NTT_SEQ_MULT_EN
    if (is_mult) begin
      sel_a   = {pair_q, 1'b0};
      sel_b   = {pair_q, 1'b1};
      sel_tw  = {1'b1, pair_q[6:1]};
      sel_neg = pair_q[0];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pair_d  = pair_q;
    layer_d = layer_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_ISSUE;
          op_d    = op;
          pair_d  = 7'd0;
          layer_d = 3'd0;
          k_d     = (op == 2'd1) ? 7'd127 : 7'd1;
        end
      end
      S_ISSUE: begin
        pair_d = pair_q + 7'd1;
        // k stays put after the final group so it never wraps inside a run.
        if (grp_end && !(last_layer && last_pair))
          k_d = is_inv ? (k_q - 7'd1) : (k_q + 7'd1);
        if (last_pair) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DCW'(D - 1)) begin
          if (last_layer) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign bu_mode   = op_q;
  assign rd_en     = (state_q == S_ISSUE);
  assign rd_addr_a = rd_en ? sel_a   : 8'd0;
  assign rd_addr_b = rd_en ? sel_b   : 8'd0;
  assign tw_idx    = rd_en ? sel_tw  : 7'd0;
  assign tw_neg    = rd_en ? sel_neg : 1'b0;

  always_comb begin
    dl_d[0] = {rd_en, rd_addr_a, rd_addr_b};
    for (int i = 1; i < D; i++) dl_d[i] = dl_q[i-1];
  end

  assign {wr_en, wr_addr_a, wr_addr_b} = dl_q[D-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      pair_q  <= 7'd0;
      layer_q <= 3'd0;
      k_q     <= 7'd0;
      drain_q <= '0;
      for (int i = 0; i < D; i++) dl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pair_q  <= pair_d;
      layer_q <= layer_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      for (int i = 0; i < D; i++) dl_q[i] <= dl_d[i];
    end
  end
endmodule

// File: tb/tb_ntt_sequencer.sv
// Directed bench for ntt_sequencer: full NTT/INVNTT address walks, reset, ignored commands.
// Define NTT_SEQ_MULT_EN for the bench too when the design is built with MULT support.
module tb_ntt_sequencer;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] op;
  logic       busy, done, rd_en, tw_neg, wr_en;
  logic [1:0] bu_mode;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_idx;

  int n_assert = 0;
  int n_fail   = 0;

  int ea [896];
  int eb [896];
  int ek [896];
  int en [896];
  int spot_cyc [4];
  logic [23:0] spot_val [4];

  ntt_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .busy(busy), .done(done), .bu_mode(bu_mode),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .tw_neg(tw_neg),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference walk written the way the Kyber reference loops are written.
  task automatic build_list(input int o);
    int idx, k;
    idx = 0;
    if (o == 0) begin
      k = 1;
      for (int len = 128; len >= 2; len = len / 2)
        for (int st = 0; st < 256; st = st + 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            ea[idx] = j; eb[idx] = j + len; ek[idx] = k; en[idx] = 0; idx++;
          end
          k++;
        end
    end else if (o == 1) begin
      k = 127;
      for (int len = 2; len <= 128; len = len * 2)
        for (int st = 0; st < 256; st = st + 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            ea[idx] = j; eb[idx] = j + len; ek[idx] = k; en[idx] = 0; idx++;
          end
          k--;
        end
    end else begin
      for (int p = 0; p < 128; p++) begin
        ea[p] = 2 * p; eb[p] = 2 * p + 1; ek[p] = 64 + p / 2; en[p] = p % 2;
      end
    end
  endtask

  // Index of the pair expected on the read port at cycle c, or -1 when rd_en must be low.
  function automatic int exp_idx(input int c, input int nl);
    if (c < 1 || c > nl * 132) return -1;
    if (((c - 1) % 132) >= 128) return -1;
    return ((c - 1) / 132) * 128 + (c - 1) % 132;
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 2'd0;
    step; step;
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_assert++;
      if ({busy, done, bu_mode, rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_neg, wr_en, wr_addr_a, wr_addr_b} !== 45'd0) begin
        n_fail++;
        $display("FAIL reset_state c=%0d got busy=%0b done=%0b rd_en=%0b wr_en=%0b a=%0d b=%0d tw=%0d mode=%0d required all zero",
                 c, busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, bu_mode);
      end
      step;
    end
    $display("test_reset complete");
  endtask

  task automatic test_unsupported(input logic [1:0] o);
    start = 1'b1; op = o;
    step;
    start = 1'b0; op = 2'd0;
    for (int c = 0; c < 5; c++) begin
      n_assert++;
      if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
        n_fail++;
        $display("FAIL unsupported_op op=%0d c=%0d got busy=%0b done=%0b rd_en=%0b wr_en=%0b required 0000",
                 o, c, busy, done, rd_en, wr_en);
      end
      step;
    end
    $display("test_unsupported op=%0d complete", o);
  endtask

  task automatic test_run(input int o, input bit noisy, input int nl);
    int done_cyc, ri, wi;
    logic [24:0] exp_rd;
    logic [16:0] exp_wr;
    build_list(o);
    done_cyc = 1 + nl * 132;
    start = 1'b1; op = 2'(o);
    step;
    start = 1'b0;
    for (int cyc = 1; cyc <= done_cyc + 5; cyc++) begin
      ri = exp_idx(cyc, nl);
      wi = exp_idx(cyc - 4, nl);
      exp_rd = (ri < 0) ? 25'd0 : {1'b1, 8'(ea[ri]), 8'(eb[ri]), 7'(ek[ri]), 1'(en[ri])};
      exp_wr = (wi < 0) ? 17'd0 : {1'b1, 8'(ea[wi]), 8'(eb[wi])};
      n_assert++;
      if ({rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_neg} !== exp_rd) begin
        n_fail++;
        $display("FAIL rd_port op=%0d cyc=%0d got en=%0b a=%0d b=%0d tw=%0d neg=%0b required en=%0b a=%0d b=%0d tw=%0d neg=%0b",
                 o, cyc, rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_neg,
                 exp_rd[24], exp_rd[23:16], exp_rd[15:8], exp_rd[7:1], exp_rd[0]);
      end
      n_assert++;
      if ({wr_en, wr_addr_a, wr_addr_b} !== exp_wr) begin
        n_fail++;
        $display("FAIL wr_port op=%0d cyc=%0d got en=%0b a=%0d b=%0d required en=%0b a=%0d b=%0d",
                 o, cyc, wr_en, wr_addr_a, wr_addr_b, exp_wr[16], exp_wr[15:8], exp_wr[7:0]);
      end
      n_assert++;
      if ({busy, done} !== {(cyc <= done_cyc), (cyc == done_cyc)}) begin
        n_fail++;
        $display("FAIL busy_done op=%0d cyc=%0d got busy=%0b done=%0b required busy=%0b done=%0b",
                 o, cyc, busy, done, (cyc <= done_cyc), (cyc == done_cyc));
      end
      if (cyc <= done_cyc) begin
        n_assert++;
        if (bu_mode !== 2'(o)) begin
          n_fail++;
          $display("FAIL bu_mode op=%0d cyc=%0d got %0d required %0d", o, cyc, bu_mode, o);
        end
      end
      for (int s = 0; s < 4; s++) begin
        if (cyc == spot_cyc[s]) begin
          n_assert++;
          if ({rd_addr_a, rd_addr_b, tw_idx, tw_neg} !== spot_val[s]) begin
            n_fail++;
            $display("FAIL spot op=%0d cyc=%0d got a=%0d b=%0d tw=%0d neg=%0b required a=%0d b=%0d tw=%0d neg=%0b",
                     o, cyc, rd_addr_a, rd_addr_b, tw_idx, tw_neg,
                     spot_val[s][23:16], spot_val[s][15:8], spot_val[s][7:1], spot_val[s][0]);
          end
        end
      end
      // Commands arriving while busy must not disturb the run.
      if (noisy && cyc >= 10 && cyc <= 20) begin
        start = 1'b1; op = 2'd3 - 2'(o);
      end else begin
        start = 1'b0; op = 2'd0;
      end
      step;
    end
    $display("test_run op=%0d noisy=%0b complete", o, noisy);
  endtask

  task automatic test_reset_mid;
    start = 1'b1; op = 2'd0;
    step;
    start = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_assert++;
    if ({busy, done, bu_mode, rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_neg, wr_en, wr_addr_a, wr_addr_b} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got busy=%0b rd_en=%0b wr_en=%0b wa=%0d wb=%0d a=%0d b=%0d required all zero",
               busy, rd_en, wr_en, wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b);
    end
    for (int c = 0; c < 10; c++) begin
      step;
      n_assert++;
      if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_mid_quiet c=%0d got busy=%0b done=%0b rd_en=%0b wr_en=%0b required 0000",
                 c, busy, done, rd_en, wr_en);
      end
    end
    $display("test_reset_mid complete");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0;
    step;
    test_reset;
    test_unsupported(2'd3);
`ifndef NTT_SEQ_MULT_EN
    test_unsupported(2'd2);
`endif
    spot_cyc = '{1, 128, 793, 920};
    spot_val = '{{8'd0, 8'd128, 7'd1, 1'b0}, {8'd127, 8'd255, 7'd1, 1'b0},
                 {8'd0, 8'd2, 7'd64, 1'b0},  {8'd253, 8'd255, 7'd127, 1'b0}};
    test_run(0, 1'b0, 7);
    spot_val = '{{8'd0, 8'd2, 7'd127, 1'b0},  {8'd253, 8'd255, 7'd64, 1'b0},
                 {8'd0, 8'd128, 7'd1, 1'b0},  {8'd127, 8'd255, 7'd1, 1'b0}};
    test_run(1, 1'b1, 7);
    test_reset_mid;
    spot_val = '{{8'd0, 8'd128, 7'd1, 1'b0}, {8'd127, 8'd255, 7'd1, 1'b0},
                 {8'd0, 8'd2, 7'd64, 1'b0},  {8'd253, 8'd255, 7'd127, 1'b0}};
    test_run(0, 1'b1, 7);
`ifdef NTT_SEQ_MULT_EN
    spot_cyc = '{1, 2, 3, 128};
    spot_val = '{{8'd0, 8'd1, 7'd64, 1'b0}, {8'd2, 8'd3, 7'd64, 1'b1},
                 {8'd4, 8'd5, 7'd65, 1'b0}, {8'd254, 8'd255, 7'd127, 1'b1}};
    test_run(2, 1'b0, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
